// File: rtl/cpu_shifter_iter.sv
// Multi-cycle shifter for EX: up to STEP bit positions per clock.
// Define CPU_SHIFTER_ROT_EN to build ROL/ROR support.
module cpu_shifter_iter #(
  parameter int XLEN = 32,
  parameter int STEP = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] src_a_i,
  input  logic [XLEN-1:0] src_b_i,
  output logic            ready_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] res_o
);

  localparam int LW = $clog2(XLEN);
  localparam int W  = LW + 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    cnt_q, cnt_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            right_q, right_d;
  logic            arith_q, arith_d;
  logic            rot_in;
  logic [W-1:0]    amt;
  logic [W-1:0]    step_amt;
  logic [XLEN-1:0] step_res;

`ifdef CPU_SHIFTER_ROT_EN
  logic rot_q, rot_d;
  assign rot_in = op_i[2];
`else
  logic unused_rot;
  assign unused_rot = op_i[2];
  assign rot_in     = 1'b0;
`endif

  // Rotates wrap mod XLEN; shifts saturate to XLEN on any high bit.
  always_comb begin
    amt = {1'b0, src_b_i[LW-1:0]};
    if (!rot_in && (|src_b_i[XLEN-1:LW])) begin
      amt = W'(XLEN);
    end
  end

  assign step_amt = (cnt_q <= W'(STEP)) ? cnt_q : W'(STEP);

  always_comb begin
    step_res = res_q;
    for (int i = 0; i <= STEP; i++) begin
      if (step_amt == W'(i)) begin
`ifdef CPU_SHIFTER_ROT_EN
        if (rot_q) begin
          if (right_q) begin
            step_res = (res_q >> i) | (res_q << (XLEN - i));
          end else begin
            step_res = (res_q << i) | (res_q >> (XLEN - i));
          end
        end else
`endif
        if (!right_q) begin
          step_res = res_q << i;
        end else if (arith_q) begin
          step_res = $signed(res_q) >>> i;
        end else begin
          step_res = res_q >> i;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    right_d = right_q;
    arith_d = arith_q;
`ifdef CPU_SHIFTER_ROT_EN
    rot_d   = rot_q;
`endif
    if (flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          state_d = IDLE;
          if (start_i) begin
            state_d = SHIFT;
            res_d   = src_a_i;
            cnt_d   = amt;
            right_d = op_i[0];
            arith_d = op_i[1] & op_i[0] & ~rot_in;
`ifdef CPU_SHIFTER_ROT_EN
            rot_d   = rot_in;
`endif
          end
        end
        SHIFT: begin
          res_d = step_res;
          if (cnt_q <= W'(STEP)) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q - W'(STEP);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      right_q <= 1'b0;
      arith_q <= 1'b0;
`ifdef CPU_SHIFTER_ROT_EN
      rot_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      right_q <= right_d;
      arith_q <= arith_d;
`ifdef CPU_SHIFTER_ROT_EN
      rot_q   <= rot_d;
`endif
    end
  end

  assign ready_o = (state_q != SHIFT);
  assign busy_o  = (state_q == SHIFT);
  assign done_o  = (state_q == DONE);
  assign res_o   = res_q;

endmodule

// File: tb/tb_cpu_shifter_iter.sv
// Randomized bench for cpu_shifter_iter against an arithmetic model.
// Covers latency, results, back-to-back, ignored start, flush, reset.
module tb_cpu_shifter_iter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        ready, busy, done;
  logic [31:0] res;

  int n_tests = 0;
  int n_fail  = 0;

  cpu_shifter_iter #(.XLEN(32), .STEP(4)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (start),
    .flush_i (flush),
    .op_i    (op),
    .src_a_i (a),
    .src_b_i (b),
    .ready_o (ready),
    .busy_o  (busy),
    .done_o  (done),
    .res_o   (res)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit rot_on(input logic [2:0] o);
`ifdef CPU_SHIFTER_ROT_EN
    return o[2];
`else
    return 1'b0 & o[2];
`endif
  endfunction

  function automatic int eff_amt(input logic [31:0] bb, input logic [2:0] o);
    if (rot_on(o)) return int'(bb % 32);
    return (bb >= 32) ? 32 : int'(bb);
  endfunction

  function automatic int ref_lat(input logic [31:0] bb, input logic [2:0] o);
    int m;
    m = eff_amt(bb, o);
    return (m == 0) ? 1 : (m + 3) / 4;
  endfunction

  function automatic logic [31:0] ref_res(input logic [31:0] aa,
                                          input logic [31:0] bb,
                                          input logic [2:0]  o);
    logic [63:0]        t;
    logic signed [63:0] s;
    int                 m;
    m = eff_amt(bb, o);
    t = {aa, aa};
    if (rot_on(o)) begin
      if (o[0]) begin
        t = t >> m;
        return t[31:0];
      end
      t = t << m;
      return t[63:32];
    end
    if (m == 32 && !(o[0] && o[1])) return 32'd0;
    if (!o[0]) return aa << m;
    if (o[1]) begin
      s = {{32{aa[31]}}, aa};
      s = s >>> m;
      return s[31:0];
    end
    return aa >> m;
  endfunction

  // Starts one op now (called #1 after an edge) and follows it to done.
  task automatic do_op(input logic [31:0] ia, input logic [31:0] ib,
                       input logic [2:0] iop, input bit poke);
    int          n, nb, k;
    bit          seen;
    logic [31:0] exp;
    exp = ref_res(ia, ib, iop);
    k   = ref_lat(ib, iop);
    check("ready_pre", 32'(ready), 32'd1);
    a = ia;
    b = ib;
    op = iop;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    op = 3'($urandom);
    n = 1;
    nb = 0;
    seen = 1'b0;
    check("acc_busy", 32'(busy), 32'd1);
    check("acc_done", 32'(done), 32'd0);
    while (n <= 200) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) nb++;
      @(posedge clk);
      #1;
      n++;
      start = poke && (n == 2) && !done;
    end
    start = 1'b0;
    check("done_seen", 32'(seen), 32'd1);
    if (seen) begin
      check("latency", 32'(n), 32'(k + 1));
      check("busy_cycles", 32'(nb), 32'(k));
      check("result", res, exp);
      check("ready_done", 32'(ready), 32'd1);
    end
  endtask

  task automatic idle(input int c);
    repeat (c) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    bit          anydone;
    logic [31:0] rb;
    repeat (2) @(posedge clk);
    #1;
    check("rst_res", res, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    idle(1);

    do_op(32'h0000_0001, 32'd5, 3'b000, 1'b0);
    idle(1);
    do_op(32'h8000_0000, 32'd40, 3'b011, 1'b1);
    idle(1);
    do_op(32'h8000_0000, 32'd40, 3'b001, 1'b0);
    idle(1);
    do_op(32'hDEAD_BEEF, 32'd0, 3'b001, 1'b0);
    idle(1);
    do_op(32'hDEAD_BEEF, 32'h100, 3'b001, 1'b0);
    idle(1);
    do_op(32'h0000_0001, 32'd36, 3'b101, 1'b0);
    idle(1);
    do_op(32'h8765_4321, 32'd13, 3'b100, 1'b1);
    idle(1);

    do_op(32'h0000_0003, 32'd1, 3'b000, 1'b0);
    do_op(32'h0000_00F0, 32'd4, 3'b001, 1'b0);
    idle(1);
    check("b2b_done_low", 32'(done), 32'd0);

    a = 32'h0000_0001;
    b = 32'd20;
    op = 3'b000;
    start = 1'b1;
    idle(1);
    start = 1'b0;
    idle(1);
    flush = 1'b1;
    idle(1);
    flush = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_ready", 32'(ready), 32'd1);
    anydone = done;
    repeat (10) begin
      idle(1);
      anydone |= done;
    end
    check("flush_nodone", 32'(anydone), 32'd0);
    do_op(32'h0000_00A5, 32'd7, 3'b000, 1'b0);
    idle(1);

    a = 32'hFFFF_0000;
    b = 32'd30;
    op = 3'b001;
    start = 1'b1;
    idle(1);
    start = 1'b0;
    idle(1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_res", res, 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ready", 32'(ready), 32'd1);
    check("mid_rst_done", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    check("post_rst_done", 32'(done), 32'd0);
    do_op(32'h1234_5678, 32'd9, 3'b011, 1'b0);
    idle(1);

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0: rb = 32'($urandom_range(0, 40));
        1: rb = $urandom;
        2: rb = 32'd1 << $urandom_range(5, 31);
        default: rb = 32'($urandom_range(0, 63));
      endcase
      do_op($urandom, rb, 3'($urandom), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle(1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
